// File: rtl/imem_loader.sv
// Program loader: assembles UART bytes MSB-first into instruction words and
// writes them to instruction memory from address 0 until HALT or memory full.
module imem_loader #(
    parameter int                 NB_INST   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 MEM_SIZE  = 128,
    parameter int                 ADDR_W    = 7,
    parameter logic [NB_INST-1:0] HALT_INST = 32'hF800_0000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic               o_en_write,
    output logic [ADDR_W-1:0]  o_addr,
    output logic [NB_INST-1:0] o_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [ADDR_W:0]    o_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    state_t             r_state;
    logic [1:0]         r_byte_cnt;
    logic [NB_INST-1:0] r_buf;
    logic               r_en_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [NB_INST-1:0] r_data;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic [ADDR_W:0]    r_count;

    logic [NB_INST-1:0] w_shifted;

    assign w_shifted = {r_buf[NB_INST-NB_BYTE-1:0], i_rx_data};

    // NOTE: every state register uses <= so all of them update from the same
    // pre-edge values; a blocking = here would create ordering-dependent races.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_buf      <= '0;
            r_en_write <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else begin
            r_en_write <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state    <= ST_RECV;
                        r_byte_cnt <= '0;
                        r_addr     <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                ST_RECV: begin
                    if (i_rx_done) begin
                        r_buf <= w_shifted;
                        if (r_byte_cnt == 2'd3) begin
                            r_byte_cnt <= '0;
                            r_data     <= w_shifted;
                            r_en_write <= 1'b1;
                            r_state    <= ST_WRITE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

                ST_WRITE: begin
                    r_count <= r_count + 1'b1;
                    // A byte landing in the write cycle starts the next word.
                    if (i_rx_done) begin
                        r_buf      <= w_shifted;
                        r_byte_cnt <= 2'd1;
                    end
                    if (r_data == HALT_INST) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b0;
                    end else if (r_addr == LAST_ADDR) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= ST_RECV;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_en_write = r_en_write;
    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_count    = r_count;

endmodule
